eth_line_packer: RTL and testbench

Parametrised frame-to-Ethernet packetiser. Pulls 16-bit pixels from the SDRAM read path, packs `LINES_PER_PKT` image lines per packet behind a 32-bit header word, and buffers each packet in a local FIFO. It hands the packet to the Ethernet TX engine with a start pulse and a byte count, then paces packets and frames with programmable gaps. It sits between the SDRAM read FIFO and the UDP/MAC transmit block.

---
 rtl/eth_pkt_pkg.sv | 38 +++
 rtl/sync_fifo_w32.sv | 63 ++++++
 rtl/eth_line_packer.sv | 252 +++++++++++++++++++++++++
 tb/tb_eth_line_packer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkt_pkg.sv
// Shared types, constants and the CRC helper for the Ethernet line packer.
// The CRC helper is only used when ETH_PKT_CRC_EN is defined.
package eth_pkt_pkg;

    localparam int HDR_W = 32;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    localparam int B_IDLE  = 0;
    localparam int B_GAP   = 1;
    localparam int B_FILL  = 2;
    localparam int B_SEND  = 3;
    localparam int B_FEND  = 4;

    typedef enum logic [4:0] {
        S_IDLE      = 5'b00001,
        S_GAP       = 5'b00010,
        S_FILL      = 5'b00100,
        S_SEND      = 5'b01000,
        S_FRAME_END = 5'b10000
    } state_t;

    // MSB-first CRC-16-CCITT over one 16-bit halfword.
    function automatic logic [15:0] crc16_step(
        input logic [15:0] crc,
        input logic [15:0] data16
    );
        logic [15:0] c;
        c = crc ^ data16;
        for (int i = 0; i < 16; i++) begin
            if (c[15]) c = {c[14:0], 1'b0} ^ CRC_POLY;
            else       c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/sync_fifo_w32.sv
// Single-clock 32-bit packet FIFO with registered read port and sync flush.
// The read word holds its last value when popped while empty.
module sync_fifo_w32 #(
    parameter int DEPTH = 4096
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        flush,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    input  logic        rd_en,
    output logic [31:0] rd_data,
    output logic        empty,
    output logic        full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
    localparam logic [AW:0]   CAP  = (AW + 1)'(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;
    logic          wr_ok;
    logic          rd_ok;

    assign empty = (count == '0);
    assign full  = (count == CAP);
    assign wr_ok = wr_en & ~full;
    assign rd_ok = rd_en & ~empty;

    always_ff @(posedge sys_clk) begin
        if (wr_ok) mem[wptr] <= wr_data;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            rd_data <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr_ok) begin
                wptr <= (wptr == LAST) ? '0 : wptr + 1'b1;
            end
            if (rd_ok) begin
                rd_data <= mem[rptr];
                rptr    <= (rptr == LAST) ? '0 : rptr + 1'b1;
            end
            unique case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/eth_line_packer.sv
// Packs image lines behind a header word into packets for the Ethernet TX.
// Define ETH_PKT_CRC_EN to append a CRC-16-CCITT trailer word.
module eth_line_packer #(
    parameter int          H_PIXEL        = 1920,
    parameter int          V_PIXEL        = 1080,
    parameter int          LINES_PER_PKT  = 1,
    parameter logic [23:0] CNT_IDLE_WAIT  = 24'h000D99,
    parameter logic [23:0] CNT_FRAME_WAIT = 24'h000FFF,
    parameter int          FIFO_DEPTH     = 4096
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        tx_en,
    input  logic [15:0] pix_data,
    output logic        pix_rd_req,
    output logic        rd_vsync,
    input  logic        eth_tx_req,
    input  logic        eth_tx_done,
    output logic        eth_tx_start,
    output logic [31:0] eth_tx_data,
    output logic [15:0] eth_tx_data_num,
    output logic        tx_underflow
);

    import eth_pkt_pkg::*;

    localparam int NPIX = LINES_PER_PKT * H_PIXEL;
    localparam int CW   = $clog2(NPIX + 1);

`ifdef ETH_PKT_CRC_EN
    localparam int          TRL_BYTES = 4;
    localparam logic [7:0]  HDR_FLAG  = 8'h80;
`else
    localparam int          TRL_BYTES = 0;
    localparam logic [7:0]  HDR_FLAG  = 8'h00;
`endif

    localparam logic [15:0] PKT_BYTES = 16'(4 + 2 * NPIX + TRL_BYTES);
    localparam logic [7:0]  LINE_BYTE = 8'(LINES_PER_PKT) | HDR_FLAG;
    localparam logic [15:0] LINES_16  = 16'(LINES_PER_PKT);
    localparam logic [15:0] V_16      = 16'(V_PIXEL);

    if (H_PIXEL % 2 != 0) begin : g_chk_h
        $error("H_PIXEL must be even");
    end
    if (LINES_PER_PKT < 1 || LINES_PER_PKT > 4) begin : g_chk_l
        $error("LINES_PER_PKT must be 1..4");
    end
    if (V_PIXEL % LINES_PER_PKT != 0) begin : g_chk_v
        $error("V_PIXEL must be a multiple of LINES_PER_PKT");
    end
    if (FIFO_DEPTH < NPIX / 2 + 2) begin : g_chk_d
        $error("FIFO_DEPTH too small for one packet");
    end
    if (4 + 2 * NPIX + TRL_BYTES > 65535) begin : g_chk_n
        $error("packet byte count exceeds 16 bits");
    end

    state_t          state;
    logic [23:0]     gap_cnt;
    logic [23:0]     gap_nxt;
    logic [15:0]     cnt_v;
    logic [15:0]     cnt_nxt;
    logic [7:0]      frame_id;
    logic            hdr_phase;
    logic [CW-1:0]   req_cnt;
    logic            pix_vld;
    logic            half;
    logic [15:0]     pix_lo;
    logic            last_pix;
    logic            wr_en;
    logic            wr_fire;
    logic [HDR_W-1:0] wr_data;
    logic            fifo_flush;
    logic            fifo_empty;
    logic            fifo_full;

`ifdef ETH_PKT_CRC_EN
    logic [15:0]     crc;
    logic            crc_pend;
`endif

    assign gap_nxt    = gap_cnt + 24'd1;
    assign cnt_nxt    = cnt_v + LINES_16;
    // Requests are contiguous, so data still arriving after the request
    // line drops is the final pixel of the packet.
    assign last_pix   = pix_vld & ~pix_rd_req;
    assign fifo_flush = (state == S_SEND) & eth_tx_done;
    assign wr_fire    = wr_en & ~fifo_full;

    always_comb begin
        wr_en   = 1'b0;
        wr_data = '0;
        if (state == S_FILL) begin
            if (hdr_phase) begin
                wr_en   = 1'b1;
                wr_data = {frame_id, LINE_BYTE, cnt_v};
            end else if (pix_vld && half) begin
                wr_en   = 1'b1;
                wr_data = {pix_data, pix_lo};
            end
`ifdef ETH_PKT_CRC_EN
            else if (crc_pend) begin
                wr_en   = 1'b1;
                wr_data = {16'h0000, crc};
            end
`endif
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pix_vld <= 1'b0;
            half    <= 1'b0;
            pix_lo  <= '0;
        end else begin
            pix_vld <= pix_rd_req;
            if (state == S_FILL && hdr_phase) begin
                half <= 1'b0;
            end else if (pix_vld) begin
                half <= ~half;
                if (!half) pix_lo <= pix_data;
            end
        end
    end

`ifdef ETH_PKT_CRC_EN
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            crc <= CRC_INIT;
        end else if (state == S_FILL && hdr_phase) begin
            crc <= CRC_INIT;
        end else if (pix_vld) begin
            crc <= crc16_step(crc, pix_data);
        end
    end
`endif

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state           <= S_IDLE;
            gap_cnt         <= '0;
            cnt_v           <= '0;
            frame_id        <= '0;
            hdr_phase       <= 1'b0;
            req_cnt         <= '0;
            pix_rd_req      <= 1'b0;
            rd_vsync        <= 1'b0;
            eth_tx_start    <= 1'b0;
            eth_tx_data_num <= '0;
`ifdef ETH_PKT_CRC_EN
            crc_pend        <= 1'b0;
`endif
        end else begin
            eth_tx_start <= 1'b0;
            unique case (1'b1)
                state[B_IDLE]: begin
                    cnt_v <= '0;
                    if (!tx_en) begin
                        gap_cnt <= '0;
                    end else if (gap_nxt >= CNT_IDLE_WAIT) begin
                        gap_cnt   <= '0;
                        hdr_phase <= 1'b1;
                        state     <= S_FILL;
                    end else begin
                        gap_cnt <= gap_nxt;
                    end
                end
                state[B_GAP]: begin
                    if (gap_nxt >= CNT_IDLE_WAIT) begin
                        gap_cnt   <= '0;
                        hdr_phase <= 1'b1;
                        state     <= S_FILL;
                    end else begin
                        gap_cnt <= gap_nxt;
                    end
                end
                state[B_FILL]: begin
                    if (hdr_phase) begin
                        hdr_phase       <= 1'b0;
                        pix_rd_req      <= 1'b1;
                        req_cnt         <= CW'(1);
                        eth_tx_data_num <= PKT_BYTES;
                    end else if (pix_rd_req) begin
                        if (req_cnt == CW'(NPIX)) pix_rd_req <= 1'b0;
                        else req_cnt <= req_cnt + 1'b1;
                    end
`ifdef ETH_PKT_CRC_EN
                    if (last_pix) crc_pend <= 1'b1;
                    if (crc_pend) begin
                        crc_pend     <= 1'b0;
                        eth_tx_start <= 1'b1;
                        state        <= S_SEND;
                    end
`else
                    if (last_pix) begin
                        eth_tx_start <= 1'b1;
                        state        <= S_SEND;
                    end
`endif
                end
                state[B_SEND]: begin
                    if (eth_tx_done) begin
                        cnt_v   <= cnt_nxt;
                        gap_cnt <= '0;
                        if (cnt_nxt == V_16) begin
                            rd_vsync <= 1'b1;
                            state    <= S_FRAME_END;
                        end else begin
                            state <= S_GAP;
                        end
                    end
                end
                state[B_FEND]: begin
                    if (gap_nxt >= CNT_FRAME_WAIT) begin
                        gap_cnt  <= '0;
                        cnt_v    <= '0;
                        rd_vsync <= 1'b0;
                        frame_id <= frame_id + 8'd1;
                        state    <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_nxt;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tx_underflow <= 1'b0;
        end else if (eth_tx_req && fifo_empty) begin
            tx_underflow <= 1'b1;
        end
    end

    sync_fifo_w32 #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .flush     (fifo_flush),
        .wr_en     (wr_fire),
        .wr_data   (wr_data),
        .rd_en     (eth_tx_req),
        .rd_data   (eth_tx_data),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

endmodule

// File: tb/tb_eth_line_packer.sv
// Directed bench for eth_line_packer: 8x4 frame, 2 lines per packet.
// Expected words follow ETH_PKT_CRC_EN when the bench is built with it.
module tb_eth_line_packer;

`ifdef ETH_PKT_CRC_EN
    localparam int          NW      = 10;
    localparam logic [15:0] EXP_NUM = 16'd40;
    localparam logic [7:0]  LB      = 8'h82;
`else
    localparam int          NW      = 9;
    localparam logic [15:0] EXP_NUM = 16'd36;
    localparam logic [7:0]  LB      = 8'h02;
`endif

    logic        sys_clk     = 1'b0;
    logic        sys_rst_n   = 1'b0;
    logic        tx_en       = 1'b0;
    logic [15:0] pix_data;
    logic        pix_rd_req;
    logic        rd_vsync;
    logic        eth_tx_req  = 1'b0;
    logic        eth_tx_done = 1'b0;
    logic        eth_tx_start;
    logic [31:0] eth_tx_data;
    logic [15:0] eth_tx_data_num;
    logic        tx_underflow;

    int          n_chk      = 0;
    int          n_err      = 0;
    int          reqs       = 0;
    int          starts     = 0;
    int          exp_reqs   = 0;
    int          exp_starts = 0;
    int          exp_pix    = 0;
    logic [15:0] pix_ctr;
    logic        pix_rst    = 1'b1;

    always #20 sys_clk = ~sys_clk;

    eth_line_packer #(
        .H_PIXEL        (8),
        .V_PIXEL        (4),
        .LINES_PER_PKT  (2),
        .CNT_IDLE_WAIT  (24'd4),
        .CNT_FRAME_WAIT (24'd8),
        .FIFO_DEPTH     (16)
    ) dut (
        .sys_clk         (sys_clk),
        .sys_rst_n       (sys_rst_n),
        .tx_en           (tx_en),
        .pix_data        (pix_data),
        .pix_rd_req      (pix_rd_req),
        .rd_vsync        (rd_vsync),
        .eth_tx_req      (eth_tx_req),
        .eth_tx_done     (eth_tx_done),
        .eth_tx_start    (eth_tx_start),
        .eth_tx_data     (eth_tx_data),
        .eth_tx_data_num (eth_tx_data_num),
        .tx_underflow    (tx_underflow)
    );

    // SDRAM read-path model: one-cycle latency, incrementing pixels.
    always @(posedge sys_clk) begin
        if (pix_rst) begin
            pix_ctr  <= '0;
            pix_data <= '0;
        end else if (pix_rd_req) begin
            pix_data <= pix_ctr;
            pix_ctr  <= pix_ctr + 16'd1;
        end
        if (pix_rd_req)   reqs   <= reqs + 1;
        if (eth_tx_start) starts <= starts + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] sw_crc(input int base);
        logic [15:0] c;
        logic [15:0] d;
        logic        fb;
        c = 16'hFFFF;
        for (int p = 0; p < 16; p++) begin
            d = 16'(base + p);
            for (int b = 15; b >= 0; b--) begin
                fb = c[15] ^ d[b];
                c  = {c[14:0], 1'b0};
                if (fb) c = c ^ 16'h1021;
            end
        end
        return c;
    endfunction

    task automatic check_reset_outs(input string tag);
        chk({tag, "_req"},   32'(pix_rd_req), 32'd0);
        chk({tag, "_vsync"}, 32'(rd_vsync), 32'd0);
        chk({tag, "_start"}, 32'(eth_tx_start), 32'd0);
        chk({tag, "_data"},  eth_tx_data, 32'd0);
        chk({tag, "_num"},   32'(eth_tx_data_num), 32'd0);
        chk({tag, "_uflow"}, 32'(tx_underflow), 32'd0);
    endtask

    task automatic rx_pkt(input logic [7:0] fid, input logic [15:0] cv,
                          input int extra, input bit drop_en);
        logic [31:0] w[$];
        logic [31:0] exp_w;
        logic [31:0] exp_last;
        bit          seen;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge sys_clk);
            seen = eth_tx_start;
        end
        if (!seen) begin
            chk("start_timeout", 32'd0, 32'd1);
            return;
        end
        if (drop_en) tx_en = 1'b0;
        exp_reqs += 16;
        exp_starts++;
        chk("byte_num", 32'(eth_tx_data_num), 32'(EXP_NUM));
        chk("pix_reqs", 32'(reqs), 32'(exp_reqs));
        eth_tx_req = 1'b1;
        for (int i = 0; i < NW + extra; i++) begin
            @(negedge sys_clk);
            w.push_back(eth_tx_data);
        end
        eth_tx_req = 1'b0;
        chk("header", w[0], {fid, LB, cv});
        exp_last = '0;
        for (int i = 1; i <= 8; i++) begin
            exp_w = {16'(exp_pix + 2 * i - 1), 16'(exp_pix + 2 * i - 2)};
            chk("pix_word", w[i], exp_w);
            exp_last = exp_w;
        end
`ifdef ETH_PKT_CRC_EN
        exp_last = {16'h0000, sw_crc(exp_pix)};
        chk("crc_word", w[9], exp_last);
`endif
        for (int i = NW; i < NW + extra; i++) begin
            chk("repeat_word", w[i], exp_last);
        end
        chk("start_count", 32'(starts), 32'(exp_starts));
        eth_tx_done = 1'b1;
        @(negedge sys_clk);
        eth_tx_done = 1'b0;
        exp_pix += 16;
    endtask

    initial begin
        int  vs;
        bit  hit;
        repeat (3) @(negedge sys_clk);
        check_reset_outs("rst");
        sys_rst_n = 1'b1;
        pix_rst   = 1'b0;

        // A stray done in IDLE must not advance the line counter.
        @(negedge sys_clk);
        eth_tx_done = 1'b1;
        @(negedge sys_clk);
        eth_tx_done = 1'b0;
        repeat (3) @(negedge sys_clk);
        chk("idle_no_req", 32'(reqs), 32'd0);

        tx_en = 1'b1;
        rx_pkt(8'd0, 16'd0, 0, 1'b0);
        rx_pkt(8'd0, 16'd2, 0, 1'b0);

        vs = 0;
        for (int i = 0; i < 100; i++) begin
            if (!rd_vsync) break;
            vs++;
            @(negedge sys_clk);
        end
        chk("vsync_len", 32'(vs), 32'd8);
        chk("uflow_clear", 32'(tx_underflow), 32'd0);

        rx_pkt(8'd1, 16'd0, 1, 1'b1);
        chk("uflow_set", 32'(tx_underflow), 32'd1);
        rx_pkt(8'd1, 16'd2, 0, 1'b0);

        repeat (60) @(negedge sys_clk);
        chk("stop_no_req", 32'(reqs), 32'(exp_reqs));
        chk("stop_req_low", 32'(pix_rd_req), 32'd0);
        chk("stop_vsync", 32'(rd_vsync), 32'd0);
        chk("uflow_sticky", 32'(tx_underflow), 32'd1);

        tx_en = 1'b1;
        hit   = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge sys_clk);
            hit = (reqs == exp_reqs + 5);
        end
        chk("fill_reach", 32'(hit), 32'd1);
        sys_rst_n = 1'b0;
        pix_rst   = 1'b1;
        #1;
        check_reset_outs("midrst");
        exp_reqs = reqs;
        exp_pix  = 0;
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        pix_rst   = 1'b0;
        rx_pkt(8'd0, 16'd0, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
